// File: rtl/core_pkg.sv
// core_pkg
//  Shared definitions for the 16-bit RISC core decode path.
//  - Opcode numbering, identical to the ALU's opcode input.
//  - Instruction field bit positions.
//  - Decoded-instruction bus layout {aluop, rd, ra, rb, imm, reg_we, is_branch}.
//  - Helpers: opcode legality check and the combinational field decoder.
package core_pkg;

   localparam int IW      = 16;
   localparam int RAW     = 3;
   localparam int IMM_W   = 8;
   localparam int OPC_W   = 4;
   localparam int ALUOP_W = OPC_W + 1;

   localparam logic [OPC_W-1:0] OPC_ADD  = 4'd0;
   localparam logic [OPC_W-1:0] OPC_SUB  = 4'd1;
   localparam logic [OPC_W-1:0] OPC_OR   = 4'd2;
   localparam logic [OPC_W-1:0] OPC_AND  = 4'd3;
   localparam logic [OPC_W-1:0] OPC_XOR  = 4'd4;
   localparam logic [OPC_W-1:0] OPC_NOT  = 4'd5;
   localparam logic [OPC_W-1:0] OPC_LOAD = 4'd8;
   localparam logic [OPC_W-1:0] OPC_CMP  = 4'd9;
   localparam logic [OPC_W-1:0] OPC_SHL  = 4'd10;
   localparam logic [OPC_W-1:0] OPC_SHR  = 4'd11;
   localparam logic [OPC_W-1:0] OPC_JMPA = 4'd12;
   localparam logic [OPC_W-1:0] OPC_JMPR = 4'd13;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 9;
   localparam int FLAG_BIT = 8;
   localparam int RA_MSB   = 7;
   localparam int RA_LSB   = 5;
   localparam int RB_MSB   = 4;
   localparam int RB_LSB   = 2;
   localparam int IMM_MSB  = 7;
   localparam int IMM_LSB  = 0;

   typedef struct packed {
      logic [ALUOP_W-1:0] aluop;
      logic [RAW-1:0]     rd;
      logic [RAW-1:0]     ra;
      logic [RAW-1:0]     rb;
      logic [IMM_W-1:0]   imm;
      logic               reg_we;
      logic               is_branch;
   } dec_instr_t;

   localparam int DEC_W = $bits(dec_instr_t);

   function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
      logic legal;
      case (opc)
         OPC_ADD, OPC_SUB, OPC_OR, OPC_AND, OPC_XOR, OPC_NOT,
         OPC_LOAD, OPC_CMP, OPC_SHL, OPC_SHR, OPC_JMPA, OPC_JMPR: legal = 1'b1;
         default:                                                legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic opc_is_branch(input logic [OPC_W-1:0] opc);
      return (opc == OPC_JMPA) || (opc == OPC_JMPR);
   endfunction

   // Fields overlap on purpose: imm shares bits with rA/rB, the consumer
   // picks whichever its opcode needs.
   function automatic dec_instr_t decode_instr(input logic [IW-1:0] instr);
      dec_instr_t d;
      logic [OPC_W-1:0] opc;
      opc         = instr[OPC_MSB:OPC_LSB];
      d.aluop     = {opc, instr[FLAG_BIT]};
      d.rd        = instr[RD_MSB:RD_LSB];
      d.ra        = instr[RA_MSB:RA_LSB];
      d.rb        = instr[RB_MSB:RB_LSB];
      d.imm       = instr[IMM_MSB:IMM_LSB];
      d.is_branch = opc_is_branch(opc);
      d.reg_we    = opc_is_legal(opc) && !opc_is_branch(opc);
      return d;
   endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if
//  Bundles the fetch-side and issue-side handshakes of the decode stage.
//  - I_instr / I_instr_valid / O_instr_ready : instruction stream from fetch
//  - I_flush                                 : taken-branch flush
//  - O_dec_valid / I_dec_ready               : decoded stream toward issue
//  - O_aluop, O_rD, O_rA, O_rB, O_imm,
//    O_reg_we, O_is_branch                   : decoded fields
//  - O_illegal, O_illegal_cnt                : illegal-opcode pulse and count
//  Modports: slave = decode stage, master = the fetch/issue side driving it.
interface instr_decode_stage_if #(parameter int CNT_W = 8);
   import core_pkg::*;

   logic [IW-1:0]      I_instr;
   logic               I_instr_valid;
   logic               O_instr_ready;
   logic               I_flush;
   logic               O_dec_valid;
   logic               I_dec_ready;
   logic [ALUOP_W-1:0] O_aluop;
   logic [RAW-1:0]     O_rD;
   logic [RAW-1:0]     O_rA;
   logic [RAW-1:0]     O_rB;
   logic [IMM_W-1:0]   O_imm;
   logic               O_reg_we;
   logic               O_is_branch;
   logic               O_illegal;
   logic [CNT_W-1:0]   O_illegal_cnt;

   modport slave (
      input  I_instr, I_instr_valid, I_flush, I_dec_ready,
      output O_instr_ready, O_dec_valid, O_aluop, O_rD, O_rA, O_rB, O_imm,
             O_reg_we, O_is_branch, O_illegal, O_illegal_cnt
   );

   modport master (
      output I_instr, I_instr_valid, I_flush, I_dec_ready,
      input  O_instr_ready, O_dec_valid, O_aluop, O_rD, O_rA, O_rB, O_imm,
             O_reg_we, O_is_branch, O_illegal, O_illegal_cnt
   );

endinterface

// File: rtl/skid_buf2.sv
// skid_buf2
//  Generic 2-entry valid/ready buffer: an output (main) register plus one
//  skid register. in_ready is registered and equals "skid empty", so no
//  combinational path exists from out_ready or in_valid to in_ready.
//  Ports:
//  - clk, srst          : clock, synchronous active-high reset
//  - flush              : drop both entries, accept again next cycle
//  - in_valid/in_data/in_ready    : upstream handshake
//  - out_valid/out_data/out_ready : downstream handshake (out_data = main)
module skid_buf2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         main_valid_reg, main_valid_next;
   logic [W-1:0] main_data_reg, main_data_next;
   logic         skid_valid_reg, skid_valid_next;
   logic [W-1:0] skid_data_reg, skid_data_next;
   logic         ready_reg;
   logic         push;
   logic         main_free;

   assign push      = in_valid & ready_reg;
   // Main can take new data if it is empty or being consumed this cycle.
   assign main_free = !main_valid_reg | out_ready;

   always_comb begin
      main_valid_next = main_valid_reg;
      main_data_next  = main_data_reg;
      skid_valid_next = skid_valid_reg;
      skid_data_next  = skid_data_reg;
      if (main_free) begin
         if (skid_valid_reg) begin
            // Oldest entry first; push cannot coincide since ready is low.
            main_valid_next = 1'b1;
            main_data_next  = skid_data_reg;
            skid_valid_next = 1'b0;
         end else if (push) begin
            main_valid_next = 1'b1;
            main_data_next  = in_data;
         end else begin
            main_valid_next = 1'b0;
         end
      end else if (push) begin
         skid_valid_next = 1'b1;
         skid_data_next  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         main_valid_reg <= 1'b0;
         main_data_reg  <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
         ready_reg      <= 1'b0;
      end else if (flush) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         ready_reg      <= 1'b1;
      end else begin
         main_valid_reg <= main_valid_next;
         main_data_reg  <= main_data_next;
         skid_valid_reg <= skid_valid_next;
         skid_data_reg  <= skid_data_next;
         ready_reg      <= !skid_valid_next;
      end
   end

   assign in_ready  = ready_reg;
   assign out_valid = main_valid_reg;
   assign out_data  = main_data_reg;

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//  Decode stage of the 16-bit RISC core, between fetch and the ALU.
//  Splits each accepted instruction into ALU opcode, register selects and
//  immediate, and queues the result in a 2-entry skid buffer. Illegal opcodes
//  are accepted but dropped and counted; a flush empties the buffer and
//  discards anything accepted in the same cycle.
//  Ports:
//  - I_clk : clock, posedge
//  - I_rst : synchronous active-high reset (overrides flush)
//  - bus   : instr_decode_stage_if.slave (fetch handshake, flush,
//            decoded-output handshake, fields, illegal pulse/count)
module instr_decode_stage
   import core_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input logic                  I_clk,
   input logic                  I_rst,
   instr_decode_stage_if.slave  bus
);

   logic [OPC_W-1:0] opc;
   logic             legal;
   logic             instr_ready;
   logic             accept;
   logic             buf_in_valid;
   logic             illegal_hit;
   logic             buf_out_valid;
   dec_instr_t       dec_in;
   logic [DEC_W-1:0] dec_out_bits;
   dec_instr_t       dec_out;
   logic             illegal_reg;
   logic [CNT_W-1:0] illegal_cnt_reg;

   assign opc    = bus.I_instr[OPC_MSB:OPC_LSB];
   assign legal  = opc_is_legal(opc);
   assign dec_in = decode_instr(bus.I_instr);
   assign accept = bus.I_instr_valid & instr_ready;

   // Only legal, non-flushed instructions reach the buffer.
   assign buf_in_valid = bus.I_instr_valid & legal & !bus.I_flush;
   assign illegal_hit  = accept & !legal & !bus.I_flush;

   skid_buf2 #(.W(DEC_W)) u_buf (
      .clk       (I_clk),
      .srst      (I_rst),
      .flush     (bus.I_flush),
      .in_valid  (buf_in_valid),
      .in_data   (dec_in),
      .in_ready  (instr_ready),
      .out_valid (buf_out_valid),
      .out_data  (dec_out_bits),
      .out_ready (bus.I_dec_ready)
   );

   assign dec_out = dec_instr_t'(dec_out_bits);

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         illegal_reg     <= 1'b0;
         illegal_cnt_reg <= '0;
      end else begin
         illegal_reg <= illegal_hit;
         if (illegal_hit && (illegal_cnt_reg != {CNT_W{1'b1}})) begin
            illegal_cnt_reg <= illegal_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign bus.O_instr_ready = instr_ready;
   assign bus.O_dec_valid   = buf_out_valid;
   assign bus.O_aluop       = dec_out.aluop;
   assign bus.O_rD          = dec_out.rd;
   assign bus.O_rA          = dec_out.ra;
   assign bus.O_rB          = dec_out.rb;
   assign bus.O_imm         = dec_out.imm;
   assign bus.O_reg_we      = dec_out.reg_we;
   assign bus.O_is_branch   = dec_out.is_branch;
   assign bus.O_illegal     = illegal_reg;
   assign bus.O_illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage
//  Directed, table-driven bench for instr_decode_stage: a vector table of
//  instructions with hand-computed decoded fields is streamed through, then
//  hand-written sequences cover stall/ordering, flush, reset mid-stall and
//  illegal-counter saturation.
module tb_instr_decode_stage;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_decode_stage_if #(.CNT_W(8)) bus ();

   instr_decode_stage #(.CNT_W(8)) dut (
      .I_clk (clk),
      .I_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] instr;
      logic        legal;
      logic [23:0] fields;   // {aluop, rd, ra, rb, imm, reg_we, is_branch}
   } vec_t;

   vec_t vecs[16];
   int   errors = 0;
   int   checks = 0;
   int   exp_cnt;

   function automatic logic [23:0] f(input logic [4:0] aluop, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [7:0] imm, input logic we, input logic br);
      return {aluop, rd, ra, rb, imm, we, br};
   endfunction

   function automatic logic [23:0] dut_fields();
      return {bus.O_aluop, bus.O_rD, bus.O_rA, bus.O_rB, bus.O_imm, bus.O_reg_we, bus.O_is_branch};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.I_instr       = 16'h0000;
      bus.I_instr_valid = 1'b0;
      bus.I_flush       = 1'b0;
      bus.I_dec_ready   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      int src[4];
      int sent, got, held;
      logic acc, con;

      vecs[0]  = '{16'h0A94, 1'b1, f(5'b00000, 3'd5, 3'd4, 3'd5, 8'h94, 1'b1, 1'b0)};
      vecs[1]  = '{16'h6000, 1'b0, 24'h0};
      vecs[2]  = '{16'hF123, 1'b0, 24'h0};
      vecs[3]  = '{16'h1000, 1'b1, f(5'b00010, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0)};
      vecs[4]  = '{16'hC100, 1'b1, f(5'b11001, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1)};
      vecs[5]  = '{16'h9000, 1'b1, f(5'b10010, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0)};
      vecs[6]  = '{16'hD3FF, 1'b1, f(5'b11011, 3'd1, 3'd7, 3'd7, 8'hFF, 1'b0, 1'b1)};
      vecs[7]  = '{16'h5E2C, 1'b1, f(5'b01010, 3'd7, 3'd1, 3'd3, 8'h2C, 1'b1, 1'b0)};
      vecs[8]  = '{16'h8B6A, 1'b1, f(5'b10001, 3'd5, 3'd3, 3'd2, 8'h6A, 1'b1, 1'b0)};
      vecs[9]  = '{16'hA555, 1'b1, f(5'b10101, 3'd2, 3'd2, 3'd5, 8'h55, 1'b1, 1'b0)};
      vecs[10] = '{16'hB0F0, 1'b1, f(5'b10110, 3'd0, 3'd7, 3'd4, 8'hF0, 1'b1, 1'b0)};
      vecs[11] = '{16'h2468, 1'b1, f(5'b00100, 3'd2, 3'd3, 3'd2, 8'h68, 1'b1, 1'b0)};
      vecs[12] = '{16'h7FFF, 1'b0, 24'h0};
      vecs[13] = '{16'h3000, 1'b1, f(5'b00110, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0)};
      vecs[14] = '{16'hE000, 1'b0, 24'h0};
      vecs[15] = '{16'h4000, 1'b1, f(5'b01000, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0)};

      // ---- reset state ----
      rst = 1'b1;
      idle_inputs();
      step();
      chk("rst_dec_valid", bus.O_dec_valid, 0);
      chk("rst_ready", bus.O_instr_ready, 0);
      chk("rst_fields", dut_fields(), 0);
      chk("rst_illegal", bus.O_illegal, 0);
      chk("rst_cnt", bus.O_illegal_cnt, 0);
      rst = 1'b0;
      step();
      chk("rst_release_ready", bus.O_instr_ready, 1);
      chk("rst_release_valid", bus.O_dec_valid, 0);
      $display("txn reset: ready=%b dec_valid=%b", bus.O_instr_ready, bus.O_dec_valid);

      // ---- table stream, one instruction per cycle, downstream always ready ----
      exp_cnt = 0;
      bus.I_dec_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.I_instr_valid = 1'b1;
         bus.I_instr       = vecs[i].instr;
         step();
         if (!vecs[i].legal) exp_cnt++;
         chk("vec_ready", bus.O_instr_ready, 1);
         chk("vec_dec_valid", bus.O_dec_valid, vecs[i].legal);
         chk("vec_illegal", bus.O_illegal, !vecs[i].legal);
         chk("vec_cnt", bus.O_illegal_cnt, exp_cnt);
         if (vecs[i].legal) chk("vec_fields", dut_fields(), vecs[i].fields);
         $display("txn vec %0d instr=%h dec_valid=%b illegal=%b aluop=%b rd=%0d ra=%0d rb=%0d imm=%h we=%b br=%b cnt=%0d",
                  i, vecs[i].instr, bus.O_dec_valid, bus.O_illegal, bus.O_aluop, bus.O_rD,
                  bus.O_rA, bus.O_rB, bus.O_imm, bus.O_reg_we, bus.O_is_branch, bus.O_illegal_cnt);
      end
      bus.I_instr_valid = 1'b0;
      step();
      chk("stream_drained", bus.O_dec_valid, 0);
      chk("stream_no_pulse", bus.O_illegal, 0);

      // ---- 4 back-to-back, downstream stalls 3 cycles after the first ----
      src = '{7, 8, 9, 10};
      sent = 0; got = 0; held = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         bus.I_dec_ready   = !(cyc >= 1 && cyc <= 3);
         bus.I_instr_valid = (sent < 4);
         bus.I_instr       = (sent < 4) ? vecs[src[sent]].instr : 16'h0000;
         acc = bus.I_instr_valid & bus.O_instr_ready;
         con = bus.O_dec_valid & bus.I_dec_ready;
         if (con) begin
            chk("ord_fields", dut_fields(), vecs[src[got]].fields);
            $display("txn ord pop %0d aluop=%b imm=%h", got, bus.O_aluop, bus.O_imm);
            got++;
         end
         step();
         if (acc) sent++;
         held = held + int'(acc) - int'(con);
         chk("ord_ready", bus.O_instr_ready, held != 2);
         chk("ord_dec_valid", bus.O_dec_valid, held != 0);
      end
      chk("ord_count", got, 4);
      bus.I_instr_valid = 1'b0;
      bus.I_dec_ready   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ord_no_dup", bus.O_dec_valid, 0);
      end

      // ---- flush with both entries full and a new instruction on input ----
      bus.I_dec_ready   = 1'b0;
      bus.I_instr_valid = 1'b1;
      bus.I_instr       = vecs[11].instr;
      step();
      bus.I_instr       = vecs[13].instr;
      step();
      chk("fl_full_ready", bus.O_instr_ready, 0);
      chk("fl_full_valid", bus.O_dec_valid, 1);
      bus.I_flush       = 1'b1;
      bus.I_instr       = vecs[15].instr;
      step();
      bus.I_flush       = 1'b0;
      bus.I_instr_valid = 1'b0;
      chk("fl_dec_valid", bus.O_dec_valid, 0);
      chk("fl_ready", bus.O_instr_ready, 1);
      $display("txn flush-full: dec_valid=%b ready=%b", bus.O_dec_valid, bus.O_instr_ready);
      bus.I_dec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("fl_none_emerge", bus.O_dec_valid, 0);
      end

      // Legal instruction accepted in the flush cycle is discarded.
      bus.I_flush = 1'b1; bus.I_instr_valid = 1'b1; bus.I_instr = 16'h4000;
      step();
      bus.I_flush = 1'b0; bus.I_instr_valid = 1'b0;
      chk("fl_empty_discard", bus.O_dec_valid, 0);
      step();
      chk("fl_empty_discard2", bus.O_dec_valid, 0);

      // Illegal instruction in the flush cycle neither pulses nor counts.
      bus.I_flush = 1'b1; bus.I_instr_valid = 1'b1; bus.I_instr = 16'hE000;
      step();
      bus.I_flush = 1'b0; bus.I_instr_valid = 1'b0;
      chk("fl_illegal_pulse", bus.O_illegal, 0);
      chk("fl_illegal_cnt", bus.O_illegal_cnt, exp_cnt);
      $display("txn flush-illegal: illegal=%b cnt=%0d", bus.O_illegal, bus.O_illegal_cnt);

      // ---- reset mid-stall with 2 entries held and count 3 ----
      do_reset();
      chk("rs2_cnt_cleared", bus.O_illegal_cnt, 0);
      bus.I_dec_ready   = 1'b0;
      bus.I_instr_valid = 1'b1;
      bus.I_instr       = 16'h6000;
      for (int k = 0; k < 3; k++) step();
      bus.I_instr = 16'h1000;
      step();
      bus.I_instr = 16'h3000;
      step();
      chk("rs2_pre_cnt", bus.O_illegal_cnt, 3);
      chk("rs2_pre_ready", bus.O_instr_ready, 0);
      chk("rs2_pre_valid", bus.O_dec_valid, 1);
      rst = 1'b1;
      bus.I_flush = 1'b1;          // reset must win over flush
      bus.I_instr = 16'h7000;
      step();
      chk("rs2_dec_valid", bus.O_dec_valid, 0);
      chk("rs2_ready", bus.O_instr_ready, 0);
      chk("rs2_fields", dut_fields(), 0);
      chk("rs2_illegal", bus.O_illegal, 0);
      chk("rs2_cnt", bus.O_illegal_cnt, 0);
      rst = 1'b0;
      idle_inputs();
      step();
      chk("rs2_release_ready", bus.O_instr_ready, 1);
      chk("rs2_release_valid", bus.O_dec_valid, 0);
      $display("txn reset-mid-stall: ready=%b cnt=%0d", bus.O_instr_ready, bus.O_illegal_cnt);

      // ---- 260 illegal instructions saturate the counter ----
      bus.I_dec_ready   = 1'b1;
      bus.I_instr_valid = 1'b1;
      bus.I_instr       = 16'hF123;
      for (int k = 1; k <= 260; k++) begin
         step();
         if (k == 254) chk("sat_254", bus.O_illegal_cnt, 254);
         if (k == 255) chk("sat_255", bus.O_illegal_cnt, 255);
      end
      chk("sat_260", bus.O_illegal_cnt, 255);
      chk("sat_pulse", bus.O_illegal, 1);
      chk("sat_no_valid", bus.O_dec_valid, 0);
      $display("txn saturate: cnt=%0d", bus.O_illegal_cnt);
      bus.I_instr_valid = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
